// File: rtl/countdown_sequencer.sv
// countdown_sequencer
//
// Control FSM and time register for a 4-digit countdown timer. Presets load a
// fixed time, add pulses extend it up to MAX_TIME, and 1 Hz ticks count it down
// while running. When the count reaches zero the sequencer enters EXPIRED, where
// the display blinks at the blink_tick rate.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tick        1 Hz single-cycle decrement enable
//   blink_tick  single-cycle pulse per half blink period
//   add_u/l/r/d single-cycle add requests (ADD_U/ADD_L/ADD_R/ADD_D seconds)
//   preset_a/b  level preset switches (PRESET_A / PRESET_B seconds)
//   time_bcd    {thousands, hundreds, tens, ones}, lags the count by one clk
//   disp_en     display enable, active high
//   running     high in RUN
//   expired     high in EXPIRED
//
// Optional feature macro: LOW_FLASH_EN
//   When defined, the display also blinks in RUN while 0 < count < LOW_THRESH.

`timescale 1ns/1ps

module countdown_sequencer #(
    parameter int ADD_U      = 10,
    parameter int ADD_L      = 180,
    parameter int ADD_R      = 200,
    parameter int ADD_D      = 550,
    parameter int PRESET_A   = 15,
    parameter int PRESET_B   = 185,
    parameter int MAX_TIME   = 9999,
    parameter int LOW_THRESH = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        blink_tick,
    input  logic        add_u,
    input  logic        add_l,
    input  logic        add_r,
    input  logic        add_d,
    input  logic        preset_a,
    input  logic        preset_b,
    output logic [15:0] time_bcd,
    output logic        disp_en,
    output logic        running,
    output logic        expired
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, EXPIRED} state_t;

    // Four BCD digits can only show up to 9999, and the low-flash threshold
    // must lie inside the displayable range.
    if (MAX_TIME > 9999 || LOW_THRESH > 9999) begin : g_bad_params
        $error("countdown_sequencer: MAX_TIME and LOW_THRESH must be <= 9999");
    end

    state_t      state;
    logic [13:0] count;
    logic        phase;

    state_t      next_state;
    logic [13:0] next_count;
    logic        next_phase;
    logic        next_disp;
    logic [14:0] add_sum;
    logic [14:0] add_total;

    function automatic logic [15:0] to_bcd(input logic [13:0] v);
        return {4'(v / 14'd1000),
                4'((v / 14'd100) % 14'd10),
                4'((v / 14'd10) % 14'd10),
                4'(v % 14'd10)};
    endfunction

    // Simultaneous add pulses accumulate; the sum is formed one bit wider than
    // the count so the saturation compare sees the true total.
    always_comb begin
        add_sum = (add_u ? 15'(ADD_U) : 15'd0)
                + (add_l ? 15'(ADD_L) : 15'd0)
                + (add_r ? 15'(ADD_R) : 15'd0)
                + (add_d ? 15'(ADD_D) : 15'd0);
        add_total = {1'b0, count} + add_sum;
    end

    // Next-state logic. Priority is preset, then add, then tick; a tick that
    // coincides with an add is dropped.
    always_comb begin
        next_state = state;
        next_count = count;

        if (preset_a || preset_b) begin
            next_state = LOAD;
            next_count = preset_b ? 14'(PRESET_B) : 14'(PRESET_A);
        end else if (add_sum != 15'd0) begin
            next_state = RUN;
            next_count = (add_total > 15'(MAX_TIME)) ? 14'(MAX_TIME)
                                                     : add_total[13:0];
        end else if (tick && state == RUN && count != 14'd0) begin
            next_count = count - 14'd1;
            if (count == 14'd1) begin
                next_state = EXPIRED;
            end
        end else if (state == LOAD) begin
            next_state = (count != 14'd0) ? RUN : IDLE;
        end
    end

    // Blink phase and display enable. The phase restarts at 0 whenever a
    // blinking period begins so the display goes dark first.
    always_comb begin
        next_phase = blink_tick ? ~phase : phase;
        if (next_state == EXPIRED && state != EXPIRED) begin
            next_phase = 1'b0;
        end
`ifdef LOW_FLASH_EN
        if (next_state == RUN && next_count != 14'd0
                && next_count < 14'(LOW_THRESH)
                && !(state == RUN && count != 14'd0
                     && count < 14'(LOW_THRESH))) begin
            next_phase = 1'b0;
        end
`endif

        next_disp = 1'b1;
        if (next_state == EXPIRED) begin
            next_disp = next_phase;
        end
`ifdef LOW_FLASH_EN
        else if (next_state == RUN && next_count != 14'd0
                 && next_count < 14'(LOW_THRESH)) begin
            next_disp = next_phase;
        end
`endif
    end

    // State, count and all outputs are registered together; time_bcd converts
    // the current count, so it trails the count register by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= 14'd0;
            phase    <= 1'b0;
            time_bcd <= 16'h0000;
            disp_en  <= 1'b1;
            running  <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            phase    <= next_phase;
            time_bcd <= to_bcd(count);
            disp_en  <= next_disp;
            running  <= (next_state == RUN);
            expired  <= (next_state == EXPIRED);
        end
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Control FSM plus time register for the 4-digit countdown timer. It sits between the single-pulse button outputs, preset switches and clock-divider ticks on one side, and the 7-segment display driver on the other.
- It sequences load, add, decrement and expiry.
- It saturates time within 0..MAX_TIME seconds.
- It drives BCD digits and the display enable to the display driver.

Parameters:
- ADD_U, 10: seconds added per add_u pulse
- ADD_L, 180: seconds added per add_l pulse
- ADD_R, 200: seconds added per add_r pulse
- ADD_D, 550: seconds added per add_d pulse
- PRESET_A, 15: value loaded while preset_a is high
- PRESET_B, 185: value loaded while preset_b is high
- MAX_TIME, 9999: saturation ceiling; must be ≤ 9999
- LOW_THRESH, 200: low-time threshold (Optional Feature only)

Ports:
- clk, input, 1: system clock (100 MHz)
- rst_n, input, 1: asynchronous, active-low reset
- tick, input, 1: 1 Hz one-cycle enable pulse, clk domain
- blink_tick, input, 1: one-cycle pulse per half blink period
- add_u, add_l, add_r, add_d, input, 1 each: one-cycle add requests (already debounced and single-pulsed)
- preset_a, preset_b, input, 1 each: level preset switches, active high, synchronous to clk
- time_bcd, output, 16: {thousands, hundreds, tens, ones} BCD digits
- disp_en, output, 1: display enable to the 7-segment driver, active high
- running, output, 1: high in RUN state
- expired, output, 1: high in EXPIRED state

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, state=IDLE
  - time_bcd=16'h0000, disp_en=1, running=0, expired=0
  - blink phase register=0
- Count register:
  - 14-bit binary.
  - time_bcd is its registered BCD conversion, so time_bcd lags count by exactly 1 clk.
- Per-cycle priority: preset > add > tick.
- Presets:
  - preset_b high: count=PRESET_B, state=LOAD. preset_b wins if both are high.
  - Else preset_a high: count=PRESET_A, state=LOAD.
  - While a preset is held, adds and ticks are ignored.
- Adds:
  - sum = ADD_U·add_u + ADD_L·add_l + ADD_R·add_r + ADD_D·add_d, so simultaneous pulses accumulate.
  - count_next = min(count + sum, MAX_TIME), computed at ≥15 bits with no wrap.
  - A tick in the same cycle as a nonzero sum is discarded.
- Tick: in RUN only, count decrements by 1; count never underflows.
- States:
  - IDLE: count==0 after reset. A nonzero add goes to RUN. A preset goes to LOAD.
  - LOAD: a preset is held, no decrement. When both presets are low: go to RUN if count>0, else IDLE.
  - RUN: tick decrements. When a tick takes count from 1 to 0, go to EXPIRED in the same update.
  - EXPIRED: count=0, expired=1. A nonzero add goes to RUN. A preset goes to LOAD.
- Outputs:
  - running = (state==RUN); expired = (state==EXPIRED). Both are registered and change on the same edge as state.
- Blink:
  - Phase register toggles on every blink_tick.
  - In EXPIRED, disp_en = phase.
  - In all other states, disp_en=1.
  - Entering EXPIRED clears phase to 0 (display off first half-period).
- Boundaries:
  - MAX_TIME plus any add → MAX_TIME.
  - Tick in IDLE, LOAD or EXPIRED → no change.
  - Reset mid-RUN → IDLE, count 0, on the next observation (no clk needed).

Optional Feature:
- Macro: LOW_FLASH_EN.
- Defined: in RUN with 0 < count < LOW_THRESH, disp_en = phase (same blink as EXPIRED). Phase is cleared on the cycle count first drops below LOW_THRESH. At count ≥ LOW_THRESH, disp_en=1.
- Undefined: disp_en=1 throughout RUN; the LOW_THRESH parameter is unused.

Test Plan:
- Reset, then add_u pulse → next clk count=10, time_bcd=16'h0010 one clk later; running=1 after 3 ticks → time_bcd=16'h0007.
- preset_b held 5 cycles with add_d and tick pulsing → time_bcd=16'h0185, state LOAD. Release → RUN; one tick → 16'h0184. preset_a+preset_b both high → 16'h0185.
- preset_a, release, 15 ticks → time_bcd 0000, expired=1, running=0. 4 blink_ticks → disp_en sequence 0,1,0,1,0. Add_l → RUN, 16'h0180, disp_en=1.
- Count 9990, add_u+add_d same cycle → 9999 (saturated). Further add_r → 9999. Add_u and tick in same cycle at 100 → 110, not 109.
- Assert rst_n low mid-RUN at 0537 with no clk edge → outputs immediately 0000/disp_en=1/running=0. Release; a tick does nothing (IDLE).
- With LOW_FLASH_EN: preset_b, release, tick → 0184, disp_en toggles on blink_tick. At count 250 → disp_en stays 1.
